switch_allocator: RTL
=====================

# switch_allocator

Per-cycle switch allocator for the 5-port (N, S, E, W, L) mesh router. Takes one routed request per input FIFO head plus per-output full flags. Grants each output to at most one input using a per-output round-robin pointer. Drives crossbar selects, input FIFO pops, output-port enables and upstream credit returns, replacing free-running turn rotation with request-driven fair scheduling.

## Interface
- NPORTS, 5, number of router ports; index order N=0, S=1, E=2, W=3, L=4
- SELW, 3, width of a port index / crossbar select
- clk  input  1  router clock
- rst  input  1  reset; synchronous, active-high
- req_valid_i  input  [NPORTS]  input FIFO head holds a flit
- req_dir_i  input  [NPORTS][SELW]  output port requested by each input head (from route logic)
- req_tail_i  input  [NPORTS]  head flit is the packet's tail (used only with SWALLOC_LOCK_EN)
- out_full_i  input  [NPORTS]  output port has no downstream credit
- sel_o  output  [NPORTS][SELW]  per-output crossbar select: granted input index, or SEL_IDLE=3'd7
- remove_o  output  [NPORTS]  pop the input FIFO head this cycle
- enable_o  output  [NPORTS]  output port accepts crossbar data this cycle
- credit_o  output  [NPORTS]  credit return to upstream neighbour, one per popped flit
- err_o  output  1  pulse: an illegal request was dropped

## Operation
- Eligibility: input i is eligible for output o when req_valid_i[i], req_dir_i[i]==o, o<=4, o!=i unless o==L, and !out_full_i[o].
- Illegal request: req_dir_i>4 or a U-turn (o==i, i!=L). It is never granted and never popped. It sets err_o next cycle.
- Each output o holds ptr[o] (3 bits, range 0..4). It scans inputs ptr[o], ptr[o]+1, … mod 5 and grants the first eligible input.
- Grant to input g on output o: sel_o[o]=g, enable_o[o]=1, remove_o[g]=1. On the clock edge, ptr[o] <= (g+1) mod 5.
- No grant: sel_o[o]=SEL_IDLE, enable_o[o]=0, ptr[o] unchanged.
- An input requests only one output, so there is never more than one grant per input.
- out_full_i[o] high blocks all grants on o. Pointer is held.
- Credit: credit_o[i] <= remove_o[i], registered.

## Timing
- Grant path (sel_o, remove_o, enable_o) is combinational from inputs plus registered state, with zero-cycle latency. The flit moves FIFO head to output port in the same cycle.
- credit_o and err_o are registered: asserted one cycle after the causing cycle, for one cycle each.
- Reset values:
  - ptr[*]=0, locks cleared, credit_o=0, err_o=0.
  - While rst is high, sel_o=SEL_IDLE and remove_o=enable_o=0 regardless of requests.
- Reset mid-packet drops locks. Arbitration restarts from pointer 0 in the first cycle after rst falls.
- Throughput: each output sustains one flit per cycle. Five disjoint grants can occur in one cycle.

## Configuration
- SWALLOC_LOCK_EN defined: packet locking is active.
  - Each output holds lock_vld[o] and lock_src[o].
  - A grant of a non-tail flit sets the lock to that input. A granted tail clears it.
  - While locked, only lock_src[o] is eligible; others wait even if the output is idle.
  - While locked, ptr[o] is not advanced until the tail grant, which sets ptr[o]=(src+1) mod 5.
- SWALLOC_LOCK_EN undefined: every flit is arbitrated independently, req_tail_i is ignored, and no lock state exists.

## Structure
- noc_pkg holds:
  - port_e enum (N, S, E, W, L)
  - NPORTS, SELW, SEL_IDLE
  - an is_legal_dir(in, dir) function
- Sub-module rr_pick: 5-bit eligibility vector plus 3-bit pointer in, grant-valid and 3-bit grant index out; purely combinational. Instantiate it five times, once per output.
- Pointer, lock, credit and err registers live in switch_allocator.

## Test plan
- Single request: reset, then N requests E with E not full. Required: sel_o[E]=0, enable_o[E]=1, remove_o[N]=1 in that cycle; credit_o[N]=1 next cycle; ptr[E]=1.
- Round-robin: N, S, W, L all request E every cycle for 8 cycles. Required grant order N, S, W, L, N, S, W, L.
- Full output: W and L request N with out_full_i[N]=1 for 3 cycles. Required: no enable, no remove, ptr unchanged. After release, W is granted first.
- Illegal: S requests S, then L requests dir 6. Required: no grants, no pops, err_o pulses one cycle after each. L requesting L is legal and granted.
- Parallel: N→S, S→N, E→W, W→E, L→L in the same cycle. Required: all five enables and all five removes high together.
- Lock (SWALLOC_LOCK_EN): N sends a 3-flit packet to L while E also requests L. Required: E is not granted until N's tail is granted. E is granted the next cycle, and ptr[L]=1 after the tail.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared port encoding, widths and direction legality for the mesh router
package noc_pkg;
  typedef enum logic [2:0] {N, S, E, W, L} port_e;
  localparam int NPORTS = 5;
  localparam int SELW = 3;
  localparam logic [SELW-1:0] SEL_IDLE = 3'd7;
  function automatic logic is_legal_dir(input logic [SELW-1:0] in, input logic [SELW-1:0] dir);
    return dir <= 3'd4 && (dir != in || dir == L);
  endfunction
  function automatic logic [SELW-1:0] next_ptr(input logic [SELW-1:0] g);
    return g == 3'd4 ? 3'd0 : g + 3'd1;
  endfunction
endpackage

// File: rtl/switch_allocator_rr_pick.sv
// rr_pick: combinational round-robin pick of the first eligible input at or after ptr (mod 5)
module rr_pick
  import noc_pkg::*;
(
  input  logic [NPORTS-1:0] elig,
  input  logic [SELW-1:0]   ptr,
  output logic              vld,
  output logic [SELW-1:0]   idx
);
  always_comb begin
    vld = 1'b0;
    idx = '0;
    // Scan backwards so the last hit written is the first in round-robin order
    for (int k = NPORTS - 1; k >= 0; k--) begin
      if (elig[(int'(ptr) + k) % NPORTS]) begin
        vld = 1'b1;
        idx = SELW'((int'(ptr) + k) % NPORTS);
      end
    end
  end
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin switch allocation for the 5-port mesh router;
// define SWALLOC_LOCK_EN to hold an output for a whole packet until its tail is granted.
module switch_allocator
  import noc_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NPORTS-1:0]            req_valid_i,
  input  logic [NPORTS-1:0][SELW-1:0]  req_dir_i,
  input  logic [NPORTS-1:0]            req_tail_i,
  input  logic [NPORTS-1:0]            out_full_i,
  output logic [NPORTS-1:0][SELW-1:0]  sel_o,
  output logic [NPORTS-1:0]            remove_o,
  output logic [NPORTS-1:0]            enable_o,
  output logic [NPORTS-1:0]            credit_o,
  output logic                         err_o
);
  logic [NPORTS-1:0][SELW-1:0] ptr, gnt_idx;
  logic [NPORTS-1:0][NPORTS-1:0] elig;
  logic [NPORTS-1:0] gnt_vld, illegal, lock_ok, adv;
`ifdef SWALLOC_LOCK_EN
  logic [NPORTS-1:0] lock_vld;
  logic [NPORTS-1:0][SELW-1:0] lock_src;
  always_comb begin
    lock_ok = '0;
    adv = '0;
    for (int o = 0; o < NPORTS; o++) begin
      lock_ok[o] = !lock_vld[o];
      adv[o] = req_tail_i[gnt_idx[o]];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld <= '0;
      lock_src <= '0;
    end else begin
      for (int o = 0; o < NPORTS; o++)
        if (gnt_vld[o]) begin
          lock_vld[o] <= !req_tail_i[gnt_idx[o]];
          lock_src[o] <= gnt_idx[o];
        end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ^req_tail_i;
  assign lock_ok = '1;
  assign adv = '1;
`endif
  always_comb begin
    elig = '0;
    illegal = '0;
    remove_o = '0;
    sel_o = '0;
    for (int i = 0; i < NPORTS; i++)
      illegal[i] = req_valid_i[i] && !is_legal_dir(SELW'(i), req_dir_i[i]);
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++)
        elig[o][i] = !rst && req_valid_i[i] && !illegal[i] && req_dir_i[i] == SELW'(o)
`ifdef SWALLOC_LOCK_EN
                     && (lock_ok[o] || lock_src[o] == SELW'(i))
`endif
                     && !out_full_i[o];
      sel_o[o] = gnt_vld[o] ? gnt_idx[o] : SEL_IDLE;
    end
    for (int i = 0; i < NPORTS; i++)
      for (int o = 0; o < NPORTS; o++)
        remove_o[i] = remove_o[i] | (gnt_vld[o] && gnt_idx[o] == SELW'(i));
  end
  assign enable_o = gnt_vld;
  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    rr_pick u_pick (.elig(elig[o]), .ptr(ptr[o]), .vld(gnt_vld[o]), .idx(gnt_idx[o]));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      credit_o <= '0;
      err_o <= 1'b0;
    end else begin
      credit_o <= remove_o;
      err_o <= |illegal;
      for (int o = 0; o < NPORTS; o++)
        if (gnt_vld[o] && adv[o]) ptr[o] <= next_ptr(gnt_idx[o]);
    end
  end
endmodule
